udp_wave_router: RTL and testbench
==================================

# udp_wave_router

Parametrised successor to the two-port DA packet controller. Parses each received UDP packet as a 3-byte header (channel index, 16-bit frequency word) followed by waveform payload. Routes the payload into one of NCH DA sample FIFOs and updates that channel's scaled frequency register on every packet. Owns per-channel FIFO read arming, overflow flagging and packet error accounting. Sits between the Ethernet UDP receive core and the per-channel DA FIFOs.

## Interface
- NCH, 2: number of DA channels (1..8)
- CNT_W, 13: FIFO data-count width
- FREQ_W, 13: scaled frequency output width
- RD_THRESH, 10: FIFO fill level that arms reading
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rec_pkt_done  in  1  one-cycle end-of-packet pulse
- udp_rec_en  in  1  payload byte valid
- udp_rec_data  in  8  payload byte
- rec_byte_num  in  16  packet byte count, valid with rec_pkt_done
- chan_en  in  NCH  per-channel enable mask
- wr_data_count  in  NCH*CNT_W  per-channel FIFO fill, channel i at [i*CNT_W +: CNT_W]
- fifo_full  in  NCH  per-channel FIFO full
- ovf_clr  in  1  clears all sticky overflow flags
- fifo_wr_en  out  NCH  per-channel write strobe
- fifo_din  out  8  write data, shared by all channels
- fifo_rd_en  out  NCH  per-channel read enable
- freq  out  NCH*FREQ_W  scaled frequency per channel
- freq_upd  out  NCH  one-cycle pulse on freq update
- ovf  out  NCH  sticky: payload byte dropped on full FIFO
- pkt_err  out  1  one-cycle pulse: runt, bad channel or length mismatch
- drop_cnt  out  16  saturating count of dropped packets

## Operation
- FSM states: IDLE, HDR_FH, HDR_FL, PAYLOAD, DROP.
- IDLE + byte: byte < NCH and chan_en[byte] -> latch channel as cur_ch, go to HDR_FH; otherwise go to DROP.
- HDR_FH: latch the high byte of the frequency word. HDR_FL: latch the low byte, load freq[cur_ch], pulse freq_upd[cur_ch], go to PAYLOAD.
- PAYLOAD: each byte -> fifo_wr_en[cur_ch]=1, fifo_din=byte. If fifo_full[cur_ch]: no write, set ovf[cur_ch].
- DROP: bytes are consumed and never written.
- rec_pkt_done in any state -> IDLE. pkt_err pulses and drop_cnt increments (saturating at 0xFFFF) when any of the following holds:
  - state was DROP;
  - fewer than 3 bytes were received (runt);
  - the internal 16-bit byte counter differs from rec_byte_num.
- A runt packet leaves freq unchanged when fewer than 3 bytes arrived.
- Frequency scaling: freq = min((word*4)/5, 2^FREQ_W-1). Use an 18-bit intermediate and truncating division. Examples: 100 -> 80, 10000 -> 8000, 0xFFFF -> 8191.
- Read arming, per channel:
  - armed sets when wr_data_count >= RD_THRESH and clears when wr_data_count == 0.
  - fifo_rd_en[i] = armed[i] & (wr_data_count[i] != 0).
- chan_en deasserted mid-packet: the current packet completes normally. The mask is sampled only at the header byte.
- ovf_clr and a new overflow in the same cycle: the set wins.

## Timing
- Reset values: fifo_wr_en=0, fifo_din=0, fifo_rd_en=0, freq=0, freq_upd=0, ovf=0, pkt_err=0, drop_cnt=0, FSM=IDLE, armed=0, byte counter=0.
- fifo_wr_en and fifo_din are registered: byte at cycle t -> write at t+1.
- freq and freq_upd register one cycle after the low-frequency byte is accepted.
- pkt_err and drop_cnt update one cycle after rec_pkt_done.
- rec_pkt_done and udp_rec_en in the same cycle: the byte is processed and counted first, then the FSM returns to IDLE.
- armed is registered. fifo_rd_en is combinational from armed and the current count (one-cycle arming latency).
- Back-to-back packets: a header byte in the cycle after rec_pkt_done is accepted.
- Reset mid-packet: all state clears and no partial write completes. The next byte after reset is parsed as a header.

## Structure
- Package udp_wave_pkg holds:
  - FSM state enum;
  - HDR_LEN=3;
  - function freq_scale(word, FREQ_W), which performs scale and saturate.
- Sub-module wave_chan_ctrl is generated NCH times. It holds the armed flag, fifo_rd_en, the freq register, freq_upd and the sticky ovf for one channel.
- Top level holds the FSM, byte counter, write path, pkt_err and drop_cnt.

## Test plan
- NCH=2, packet [0x01,0x00,0x64,+16 bytes], rec_byte_num=19 -> freq[1]=80, freq_upd[1] one pulse, 16 writes on channel 1 only, pkt_err=0.
- Header 0x05 (>= NCH), 10 bytes -> no writes, pkt_err pulse, drop_cnt=1. Same result for channel 0 with chan_en[0]=0.
- 2-byte packet [0x00,0x27] -> freq[0] unchanged, pkt_err pulse. Length mismatch (19 bytes, rec_byte_num=20) -> pkt_err pulse, freq is still updated.
- Frequency word 0xFFFF -> freq=8191. Word 10000 -> freq=8000.
- wr_data_count[0] ramps 0..12 then drains -> fifo_rd_en[0] rises one cycle after count reaches 10, stays high down to 1, drops at 0.
- fifo_full[1]=1 during 4 payload bytes -> those writes are suppressed and ovf[1]=1. ovf_clr clears it. Rst mid-payload -> all outputs return to their reset values.

Source files
------------

// File: rtl/udp_wave_pkg.sv
// Shared types and helpers for the UDP waveform router: parser states,
// header length and frequency-word scaling.
package udp_wave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_FH,
    ST_HDR_FL,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam int HDR_LEN = 3;

  // word*4/5 with truncation, then clamped to the largest freq_w-bit value.
  function automatic logic [15:0] freq_scale(input logic [15:0] word, input int freq_w);
    logic [17:0] prod;
    logic [17:0] quot;
    logic [17:0] max_val;
    prod    = {word, 2'b00};
    quot    = prod / 18'd5;
    max_val = 18'((1 << freq_w) - 1);
    if (quot > max_val) return max_val[15:0];
    return quot[15:0];
  endfunction

endpackage

// File: rtl/udp_wave_router_chan.sv
// Per-channel control: read arming with hysteresis, scaled frequency
// register with update pulse, and sticky overflow flag.
module wave_chan_ctrl
  import udp_wave_pkg::*;
#(
  parameter int CNT_W     = 13,
  parameter int FREQ_W    = 13,
  parameter int RD_THRESH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  i_wr_data_count,
  input  logic              i_ovf_set,
  input  logic              i_ovf_clr,
  input  logic              i_freq_load,
  input  logic [FREQ_W-1:0] i_freq_val,
  output logic              o_fifo_rd_en,
  output logic [FREQ_W-1:0] o_freq,
  output logic              o_freq_upd,
  output logic              o_ovf
);

  logic              r_armed;
  logic [FREQ_W-1:0] r_freq;
  logic              r_freq_upd;
  logic              r_ovf;
  logic              w_cnt_zero;

  assign w_cnt_zero = (i_wr_data_count == '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_freq     <= '0;
      r_freq_upd <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_cnt_zero) r_armed <= 1'b0;
      else if (i_wr_data_count >= CNT_W'(RD_THRESH)) r_armed <= 1'b1;
      r_freq_upd <= i_freq_load;
      if (i_freq_load) r_freq <= i_freq_val;
      // A new overflow in the same cycle as a clear must survive.
      if (i_ovf_set) r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_fifo_rd_en = r_armed & ~w_cnt_zero;
  assign o_freq       = r_freq;
  assign o_freq_upd   = r_freq_upd;
  assign o_ovf        = r_ovf;

endmodule

// File: rtl/udp_wave_router.sv
// Parses UDP packets (channel, 16-bit frequency word, payload), routes the
// payload to one of NCH DA FIFOs and accounts for malformed packets.
module udp_wave_router
  import udp_wave_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CNT_W     = 13,
  parameter int FREQ_W    = 13,
  parameter int RD_THRESH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_pkt_done,
  input  logic                  udp_rec_en,
  input  logic [7:0]            udp_rec_data,
  input  logic [15:0]           rec_byte_num,
  input  logic [NCH-1:0]        chan_en,
  input  logic [NCH*CNT_W-1:0]  wr_data_count,
  input  logic [NCH-1:0]        fifo_full,
  input  logic                  ovf_clr,
  output logic [NCH-1:0]        fifo_wr_en,
  output logic [7:0]            fifo_din,
  output logic [NCH-1:0]        fifo_rd_en,
  output logic [NCH*FREQ_W-1:0] freq,
  output logic [NCH-1:0]        freq_upd,
  output logic [NCH-1:0]        ovf,
  output logic                  pkt_err,
  output logic [15:0]           drop_cnt
);

  state_t            r_state;
  state_t            w_next;
  logic [NCH-1:0]    r_cur_sel;
  logic [7:0]        r_freq_hi;
  logic [15:0]       r_byte_cnt;
  logic [NCH-1:0]    r_wr_en;
  logic [7:0]        r_din;
  logic              r_pkt_err;
  logic [15:0]       r_drop_cnt;

  logic [NCH-1:0]    w_hdr_sel;
  logic              w_hdr_ok;
  logic              w_cur_full;
  logic [15:0]       w_cnt_now;
  logic              w_err;
  logic              w_latch_hdr;
  logic              w_latch_hi;
  logic              w_wr_req;
  logic [NCH-1:0]    w_ovf_set;
  logic [NCH-1:0]    w_freq_load;
  logic [FREQ_W-1:0] w_freq_val;

  // The channel is tracked one-hot so header bytes >= NCH simply select nothing.
  always_comb begin
    for (int i = 0; i < NCH; i++) w_hdr_sel[i] = (udp_rec_data == 8'(i));
  end

  assign w_hdr_ok   = |(w_hdr_sel & chan_en);
  assign w_cur_full = |(fifo_full & r_cur_sel);
  assign w_freq_val = FREQ_W'(freq_scale({r_freq_hi, udp_rec_data}, FREQ_W));

  // Byte count including a byte arriving together with rec_pkt_done.
  assign w_cnt_now = (udp_rec_en && r_byte_cnt != 16'hFFFF) ? r_byte_cnt + 16'd1 : r_byte_cnt;

  assign w_err = (r_state == ST_DROP)
              || (r_state == ST_IDLE && udp_rec_en && !w_hdr_ok)
              || (w_cnt_now < 16'(HDR_LEN))
              || (w_cnt_now != rec_byte_num);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (udp_rec_en) w_next = w_hdr_ok ? ST_HDR_FH : ST_DROP;
      ST_HDR_FH:  if (udp_rec_en) w_next = ST_HDR_FL;
      ST_HDR_FL:  if (udp_rec_en) w_next = ST_PAYLOAD;
      ST_PAYLOAD: w_next = ST_PAYLOAD;
      ST_DROP:    w_next = ST_DROP;
      default:    w_next = ST_IDLE;
    endcase
    if (rec_pkt_done) w_next = ST_IDLE;
  end

  always_comb begin
    w_latch_hdr = 1'b0;
    w_latch_hi  = 1'b0;
    w_wr_req    = 1'b0;
    w_ovf_set   = '0;
    w_freq_load = '0;
    case (r_state)
      ST_IDLE:    w_latch_hdr = udp_rec_en & w_hdr_ok;
      ST_HDR_FH:  w_latch_hi  = udp_rec_en;
      ST_HDR_FL:  w_freq_load = udp_rec_en ? r_cur_sel : '0;
      ST_PAYLOAD: begin
        w_wr_req  = udp_rec_en & ~w_cur_full;
        w_ovf_set = (udp_rec_en & w_cur_full) ? r_cur_sel : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_sel  <= '0;
      r_freq_hi  <= '0;
      r_byte_cnt <= '0;
      r_wr_en    <= '0;
      r_din      <= '0;
      r_pkt_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_latch_hdr) r_cur_sel <= w_hdr_sel;
      if (w_latch_hi)  r_freq_hi <= udp_rec_data;
      r_byte_cnt <= rec_pkt_done ? 16'd0 : w_cnt_now;
      r_wr_en    <= w_wr_req ? r_cur_sel : '0;
      if (w_wr_req) r_din <= udp_rec_data;
      r_pkt_err  <= rec_pkt_done & w_err;
      if (rec_pkt_done && w_err && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    wave_chan_ctrl #(
      .CNT_W    (CNT_W),
      .FREQ_W   (FREQ_W),
      .RD_THRESH(RD_THRESH)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .i_wr_data_count(wr_data_count[g*CNT_W +: CNT_W]),
      .i_ovf_set      (w_ovf_set[g]),
      .i_ovf_clr      (ovf_clr),
      .i_freq_load    (w_freq_load[g]),
      .i_freq_val     (w_freq_val),
      .o_fifo_rd_en   (fifo_rd_en[g]),
      .o_freq         (freq[g*FREQ_W +: FREQ_W]),
      .o_freq_upd     (freq_upd[g]),
      .o_ovf          (ovf[g])
    );
  end

  assign fifo_wr_en = r_wr_en;
  assign fifo_din   = r_din;
  assign pkt_err    = r_pkt_err;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_udp_wave_router.sv
// Directed self-checking bench for udp_wave_router with NCH=2 and
// hand-computed expectations for routing, scaling, errors, arming and reset.
module tb_udp_wave_router;

  localparam int NCH       = 2;
  localparam int CNT_W     = 13;
  localparam int FREQ_W    = 13;
  localparam int RD_THRESH = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rec_pkt_done;
  logic                  udp_rec_en;
  logic [7:0]            udp_rec_data;
  logic [15:0]           rec_byte_num;
  logic [NCH-1:0]        chan_en;
  logic [NCH*CNT_W-1:0]  wr_data_count;
  logic [NCH-1:0]        fifo_full;
  logic                  ovf_clr;
  logic [NCH-1:0]        fifo_wr_en;
  logic [7:0]            fifo_din;
  logic [NCH-1:0]        fifo_rd_en;
  logic [NCH*FREQ_W-1:0] freq;
  logic [NCH-1:0]        freq_upd;
  logic [NCH-1:0]        ovf;
  logic                  pkt_err;
  logic [15:0]           drop_cnt;

  always #5 clk = ~clk;

  udp_wave_router #(
    .NCH(NCH), .CNT_W(CNT_W), .FREQ_W(FREQ_W), .RD_THRESH(RD_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .rec_pkt_done(rec_pkt_done), .udp_rec_en(udp_rec_en),
    .udp_rec_data(udp_rec_data), .rec_byte_num(rec_byte_num), .chan_en(chan_en),
    .wr_data_count(wr_data_count), .fifo_full(fifo_full), .ovf_clr(ovf_clr),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .freq(freq), .freq_upd(freq_upd), .ovf(ovf), .pkt_err(pkt_err), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  int wr0 = 0, wr1 = 0, upd0 = 0, upd1 = 0, errs = 0, sum1 = 0;

  logic [7:0]     pkt [0:31];
  int             ff_lo = -1, ff_hi = -1;
  logic [NCH-1:0] ff_mask = '0;
  logic           err_done;

  wire [FREQ_W-1:0] freq0 = freq[0 +: FREQ_W];
  wire [FREQ_W-1:0] freq1 = freq[FREQ_W +: FREQ_W];

  // Cumulative event counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_wr_en[0]) wr0++;
    if (fifo_wr_en[1]) begin wr1++; sum1 += int'(fifo_din); end
    if (freq_upd[0]) upd0++;
    if (freq_upd[1]) upd1++;
    if (pkt_err) errs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] ch, input logic [7:0] hi, input logic [7:0] lo);
    pkt[0] = ch;
    pkt[1] = hi;
    pkt[2] = lo;
    for (int k = 3; k < 32; k++) pkt[k] = 8'(k - 3);
  endtask

  // Last byte carries rec_pkt_done; err_at_done samples pkt_err one cycle later.
  task automatic send_pkt(input int n, input int rbn, input int gap, output logic err_at_done);
    for (int i = 0; i < n; i++) begin
      udp_rec_en   = 1'b1;
      udp_rec_data = pkt[i];
      rec_pkt_done = (i == n - 1);
      rec_byte_num = 16'(rbn);
      fifo_full    = (i >= ff_lo && i < ff_hi) ? ff_mask : '0;
      tick();
    end
    udp_rec_en   = 1'b0;
    rec_pkt_done = 1'b0;
    fifo_full    = '0;
    err_at_done  = pkt_err;
    repeat (gap) tick();
  endtask

  initial begin
    rst = 1'b1; rec_pkt_done = 1'b0; udp_rec_en = 1'b0; udp_rec_data = '0;
    rec_byte_num = '0; chan_en = 2'b11; wr_data_count = '0; fifo_full = '0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_din", 32'(fifo_din), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_freq", 32'(freq), 0);
    check("rst_upd_ovf_err", {freq_upd, ovf, pkt_err}, 0);
    check("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b0;
    tick();

    // Channel 1, word 100 -> 80, 16 payload bytes 0..15.
    load(8'h01, 8'h00, 8'h64);
    send_pkt(19, 19, 3, err_done);
    check("t1_err", 32'(err_done), 0);
    check("t1_freq1", 32'(freq1), 80);
    check("t1_freq0", 32'(freq0), 0);
    check("t1_upd1", upd1, 1);
    check("t1_upd0", upd0, 0);
    check("t1_wr1", wr1, 16);
    check("t1_wr0", wr0, 0);
    check("t1_sum1", sum1, 120);
    check("t1_errs", errs, 0);

    // Header 5 is out of range.
    load(8'h05, 8'h00, 8'h64);
    send_pkt(10, 10, 2, err_done);
    check("t2_err", 32'(err_done), 1);
    check("t2_drop", 32'(drop_cnt), 1);
    check("t2_wr", wr0 + wr1, 16);

    // Channel 0 disabled at header time.
    chan_en = 2'b10;
    load(8'h00, 8'h00, 8'h64);
    send_pkt(10, 10, 2, err_done);
    chan_en = 2'b11;
    check("t3_err", 32'(err_done), 1);
    check("t3_drop", 32'(drop_cnt), 2);
    check("t3_wr0", wr0, 0);
    check("t3_upd0", upd0, 0);

    // Runt: two bytes only.
    load(8'h00, 8'h27, 8'h10);
    send_pkt(2, 2, 2, err_done);
    check("t4_err", 32'(err_done), 1);
    check("t4_drop", 32'(drop_cnt), 3);
    check("t4_freq0", 32'(freq0), 0);
    check("t4_errs", errs, 3);

    // Length mismatch: word 10000 -> 8000; back-to-back with next packet.
    load(8'h00, 8'h27, 8'h10);
    send_pkt(19, 20, 0, err_done);
    check("t5_err", 32'(err_done), 1);
    check("t5_drop", 32'(drop_cnt), 4);
    check("t5_freq0", 32'(freq0), 8000);

    // Word 0xFFFF saturates to 8191; header in the cycle right after done.
    load(8'h01, 8'hFF, 8'hFF);
    send_pkt(3, 3, 2, err_done);
    check("t6_err", 32'(err_done), 0);
    check("t6_freq1", 32'(freq1), 8191);
    check("t6_drop", 32'(drop_cnt), 4);
    check("t5_wr0", wr0, 16);
    check("t6_upd", upd0 * 16 + upd1, 16 + 2);

    // Read arming on channel 0: count ramps 0..12 then drains to 0.
    for (int c = 0; c <= 12; c++) begin
      wr_data_count = {13'd0, 13'(c)};
      #1;
      check($sformatf("arm_up%0d", c), 32'(fifo_rd_en), (c >= 11) ? 1 : 0);
      tick();
    end
    for (int c = 11; c >= 0; c--) begin
      wr_data_count = {13'd0, 13'(c)};
      #1;
      check($sformatf("arm_dn%0d", c), 32'(fifo_rd_en), (c >= 1) ? 1 : 0);
      tick();
    end
    wr_data_count = {13'd0, 13'd5};
    #1;
    check("arm_rearm_below", 32'(fifo_rd_en), 0);
    wr_data_count = '0;
    tick();

    // Full FIFO on channel 1 during payload bytes at indices 5..8.
    load(8'h01, 8'h00, 8'h64);
    ff_mask = 2'b10; ff_lo = 5; ff_hi = 9;
    send_pkt(11, 11, 2, err_done);
    ff_lo = -1; ff_hi = -1; ff_mask = '0;
    check("t8_err", 32'(err_done), 0);
    check("t8_wr1", wr1, 20);
    check("t8_ovf", 32'(ovf), 2);
    check("t8_freq1", 32'(freq1), 80);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t8_ovf_clr", 32'(ovf), 0);

    // Reset in the middle of a channel 0 payload, with ch0 armed and overflowed.
    load(8'h00, 8'h00, 8'h64);
    wr_data_count = {13'd0, 13'd12};
    for (int i = 0; i < 6; i++) begin
      udp_rec_en   = 1'b1;
      udp_rec_data = pkt[i];
      fifo_full    = (i == 4) ? 2'b01 : 2'b00;
      tick();
    end
    fifo_full    = '0;
    udp_rec_data = pkt[6];
    check("t9_pre_ovf", 32'(ovf), 1);
    check("t9_pre_rd", 32'(fifo_rd_en), 1);
    check("t9_pre_freq0", 32'(freq0), 80);
    rst = 1'b1;
    tick();
    check("t9_wr_en", 32'(fifo_wr_en), 0);
    check("t9_din", 32'(fifo_din), 0);
    check("t9_rd_en", 32'(fifo_rd_en), 0);
    check("t9_freq", 32'(freq), 0);
    check("t9_ovf", 32'(ovf), 0);
    check("t9_drop", 32'(drop_cnt), 0);
    rst = 1'b0;
    udp_rec_en = 1'b0;
    wr_data_count = '0;
    tick();
    check("t9_wr0", wr0, 18);
    check("t9_upd0", upd0, 2);

    // The first byte after reset is parsed as a header.
    load(8'h01, 8'h00, 8'h64);
    send_pkt(5, 5, 3, err_done);
    check("t10_err", 32'(err_done), 0);
    check("t10_freq1", 32'(freq1), 80);
    check("t10_wr1", wr1, 22);
    check("t10_upd1", upd1, 4);
    check("t10_errs", errs, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
